// File: rtl/video_timing_rx.sv
// Receive side of the RGB video interface: measures line/frame geometry, locks after
// consecutive matching frames, then emits RGB565 pixels with x/y coordinates.
module video_timing_rx #(
  parameter logic [10:0] H_DISP_EXP  = 11'd1280,
  parameter logic [10:0] V_DISP_EXP  = 11'd800,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  output logic        pix_wr_en,
  output logic [15:0] pix_data,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        frame_start,
  output logic [10:0] meas_h_total,
  output logic [10:0] meas_h_disp,
  output logic [10:0] meas_v_total,
  output logic [10:0] meas_v_disp,
  output logic        timing_locked,
  output logic        timing_err
);

  localparam logic [10:0] CNT_MAX = 11'd2047;
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  logic        r_hs_s1, r_vs_s1, r_de_s1, r_hs_d, r_vs_d, r_de_d;
  logic [15:0] r_rgb_s1;
  logic [10:0] r_h_cnt, r_de_cnt, r_v_cnt, r_v_act, r_x_cnt, r_y_cnt;
  logic        r_frame_bad, r_seen_vs;
  logic [2:0]  r_match_cnt;
  state_t      r_state;

  logic        w_hs_lead, w_vs_lead, w_de_rise, w_de_fall, w_wdog, w_line_bad;
  logic        w_frame_good, w_evaluate, w_wr, w_seen_nxt, w_err_nxt;
  logic [10:0] w_h_total_new, w_h_disp_now, w_v_total_now, w_v_disp_now, w_x_cur;
  logic [2:0]  w_match_nxt;
  state_t      w_state_nxt;
  logic        w_unused;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  // Only the RGB565 bits are kept; the dropped LSBs are folded here.
  assign w_unused = ^{video_rgb[18:16], video_rgb[9:8], video_rgb[2:0]};

  assign w_hs_lead = (r_hs_s1 == HS_POL) && (r_hs_d != HS_POL);
  assign w_vs_lead = (r_vs_s1 == VS_POL) && (r_vs_d != VS_POL);
  assign w_de_rise = r_de_s1 & ~r_de_d;
  assign w_de_fall = ~r_de_s1 & r_de_d;
  assign w_wdog    = (r_h_cnt == CNT_MAX);

  // A line ending on the same edge as the frame is folded in before the frame is judged.
  assign w_h_total_new = r_h_cnt + 11'd1;
  assign w_line_bad    = (w_hs_lead && (w_h_total_new != meas_h_total)) ||
                         (w_de_fall && (r_de_cnt != meas_h_disp));
  assign w_h_disp_now  = w_de_fall ? r_de_cnt : meas_h_disp;
  assign w_v_total_now = w_hs_lead ? sat_inc(r_v_cnt) : r_v_cnt;
  assign w_v_disp_now  = w_de_fall ? sat_inc(r_v_act) : r_v_act;
  assign w_evaluate    = w_vs_lead && r_seen_vs;
  assign w_frame_good  = r_seen_vs && !(r_frame_bad || w_line_bad) &&
                         (w_h_disp_now == H_DISP_EXP) && (w_v_disp_now == V_DISP_EXP);

  assign w_x_cur = w_de_rise ? 11'd0 : r_x_cnt;
  assign w_wr    = r_de_s1 && timing_locked;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {r_hs_s1, r_vs_s1, r_de_s1, r_hs_d, r_vs_d, r_de_d} <= '0;
      r_rgb_s1     <= '0;
      r_h_cnt      <= '0;
      r_de_cnt     <= '0;
      r_v_cnt      <= '0;
      r_v_act      <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_frame_bad  <= 1'b0;
      meas_h_total <= '0;
      meas_h_disp  <= '0;
      meas_v_total <= '0;
      meas_v_disp  <= '0;
      pix_wr_en    <= 1'b0;
      pix_data     <= '0;
      pix_xpos     <= '0;
      pix_ypos     <= '0;
      frame_start  <= 1'b0;
    end else begin
      r_hs_s1  <= video_hs;
      r_vs_s1  <= video_vs;
      r_de_s1  <= video_de;
      r_rgb_s1 <= {video_rgb[23:19], video_rgb[15:10], video_rgb[7:3]};
      r_hs_d   <= r_hs_s1;
      r_vs_d   <= r_vs_s1;
      r_de_d   <= r_de_s1;

      if (w_hs_lead) begin
        meas_h_total <= w_h_total_new;
        r_h_cnt      <= '0;
      end else if (!w_wdog) begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end

      if (w_de_rise)    r_de_cnt <= 11'd1;
      else if (r_de_s1) r_de_cnt <= sat_inc(r_de_cnt);
      if (w_de_fall)    meas_h_disp <= r_de_cnt;

      if (w_vs_lead) begin
        meas_v_total <= w_v_total_now;
        meas_v_disp  <= w_v_disp_now;
        r_v_cnt      <= '0;
        r_v_act      <= '0;
        r_frame_bad  <= 1'b0;
        r_y_cnt      <= '0;
      end else begin
        r_v_cnt     <= w_v_total_now;
        r_v_act     <= w_v_disp_now;
        r_frame_bad <= r_frame_bad | w_line_bad;
        if (w_de_fall) r_y_cnt <= sat_inc(r_y_cnt);
      end

      if (r_de_s1) r_x_cnt <= sat_inc(w_x_cur);

      pix_wr_en   <= w_wr;
      frame_start <= w_wr && (w_x_cur == 11'd0) && (r_y_cnt == 11'd0);
      if (w_wr) begin
        pix_data <= r_rgb_s1;
        pix_xpos <= w_x_cur;
        pix_ypos <= r_y_cnt;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_seen_nxt  = r_seen_vs | w_vs_lead;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_wdog) begin
          w_match_nxt = '0;
          w_seen_nxt  = 1'b0;
        end else if (w_evaluate) begin
          if (!w_frame_good) begin
            w_match_nxt = '0;
          end else if (r_match_cnt + 3'd1 >= LOCK_N) begin
            w_match_nxt = '0;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_match_nxt = r_match_cnt + 3'd1;
          end
        end
      end
      ST_LOCKED: begin
        w_match_nxt = '0;
        if (w_wdog || (w_evaluate && !w_frame_good)) begin
          w_state_nxt = ST_UNLOCKED;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_UNLOCKED;
      r_match_cnt   <= '0;
      r_seen_vs     <= 1'b0;
      timing_locked <= 1'b0;
      timing_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_match_cnt   <= w_match_nxt;
      r_seen_vs     <= w_seen_nxt;
      timing_locked <= (w_state_nxt == ST_LOCKED);
      timing_err    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Randomized bench for video_timing_rx on scaled-down geometry: a frame-level lock model
// feeds a pixel scoreboard that a separate monitor drains whenever pix_wr_en is seen.
module tb_video_timing_rx;

  localparam int HD = 16;
  localparam int VD = 8;
  localparam int LOCKN = 2;

  typedef struct {
    int h_tot, h_sync, h_bp, h_act;
    int v_tot, v_sync, v_bp, v_act;
  } geo_t;

  typedef struct packed {
    logic [15:0] data;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [23:0] rgb = '0;
  logic        pix_wr_en, frame_start, timing_locked, timing_err;
  logic [15:0] pix_data;
  logic [10:0] pix_xpos, pix_ypos, meas_h_total, meas_h_disp, meas_v_total, meas_v_disp;

  int   checks = 0, failures = 0;
  int   err_seen = 0, err_exp = 0;
  int   cyc = 0, last_lead = 0;
  pix_t exp_q[$];

  bit m_seen, m_locked, m_bad;
  int m_match, m_lines, m_last_w;

  geo_t g1 = '{h_tot: 24, h_sync: 3, h_bp: 3, h_act: 16, v_tot: 12, v_sync: 2, v_bp: 1, v_act: 8};
  geo_t g2 = '{h_tot: 20, h_sync: 2, h_bp: 2, h_act: 10, v_tot: 10, v_sync: 2, v_bp: 1, v_act: 6};

  video_timing_rx #(
    .H_DISP_EXP(11'(HD)), .V_DISP_EXP(11'(VD)), .LOCK_FRAMES(LOCKN),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixel_clk(clk), .sys_rst_n(rst_n),
    .video_hs(hs), .video_vs(vs), .video_de(de), .video_rgb(rgb),
    .pix_wr_en(pix_wr_en), .pix_data(pix_data), .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
    .frame_start(frame_start),
    .meas_h_total(meas_h_total), .meas_h_disp(meas_h_disp),
    .meas_v_total(meas_v_total), .meas_v_disp(meas_v_disp),
    .timing_locked(timing_locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rgb565(input logic [23:0] v);
    int r8, g8, b8;
    r8 = (int'(v) >> 16) & 255;
    g8 = (int'(v) >> 8) & 255;
    b8 = int'(v) & 255;
    return 16'(((r8 / 8) << 11) | ((g8 / 4) << 5) | (b8 / 8));
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (timing_err) err_seen++;
      if (frame_start && !pix_wr_en) begin
        checks++;
        failures++;
        $display("FAIL frame_start_without_write: x=%0d y=%0d", pix_xpos, pix_ypos);
      end
      if (pix_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: data=%0h x=%0d y=%0d", pix_data, pix_xpos, pix_ypos);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          check("pixel", {pix_data, pix_xpos, pix_ypos, frame_start}, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_seen = 0; m_locked = 0; m_bad = 0; m_match = 0; m_lines = 0; m_last_w = 0;
  endtask

  // Frame-level lock rules applied at each frame-sync leading edge.
  task automatic model_vs();
    bit good;
    if (!m_seen) begin
      m_seen = 1;
    end else begin
      good = !m_bad && (m_last_w == HD) && (m_lines == VD);
      if (m_locked) begin
        if (!good) begin
          m_locked = 0;
          err_exp++;
        end
      end else if (good) begin
        m_match++;
        if (m_match >= LOCKN) begin
          m_locked = 1;
          m_match = 0;
        end
      end else begin
        m_match = 0;
      end
    end
    m_bad = 0;
    m_lines = 0;
  endtask

  task automatic model_watchdog();
    if (m_locked) err_exp++;
    m_locked = 0;
    m_seen = 0;
    m_match = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {pix_wr_en, pix_data, pix_xpos, pix_ypos, frame_start, meas_h_total,
                 meas_h_disp, meas_v_total, meas_v_disp, timing_locked, timing_err}, '0);
  endtask

  // Drives lines first_line..v_tot-1 of one frame; vs/hs leading edges coincide at line 0.
  task automatic drive_frame(input geo_t g, input int first_line, input int short_line,
                             input int rst_at);
    int a_idx, width, x;
    bit active;
    for (int l = first_line; l < g.v_tot; l++) begin
      if (l == 0) model_vs();
      a_idx  = l - (g.v_sync + g.v_bp);
      active = (a_idx >= 0) && (a_idx < g.v_act);
      width  = (active && a_idx == short_line) ? g.h_act - 1 : g.h_act;
      if (active) begin
        if (width != m_last_w) m_bad = 1;
        m_last_w = width;
        m_lines++;
      end
      for (int c = 0; c < g.h_tot; c++) begin
        @(posedge clk);
        #1;
        cyc++;
        hs = (c < g.h_sync) ? 1'b0 : 1'b1;
        vs = (l < g.v_sync) ? 1'b0 : 1'b1;
        x  = c - (g.h_sync + g.h_bp);
        de = active && (x >= 0) && (x < width);
        if (c == 0) last_lead = cyc;
        if (de) begin
          rgb = ($urandom_range(0, 7) == 0) ? 24'hF8FCF8 : 24'($urandom);
          if (m_locked)
            exp_q.push_back('{data: rgb565(rgb), x: 11'(x), y: 11'(a_idx),
                              fs: (x == 0 && a_idx == 0)});
        end
        if (l * g.h_tot + c == rst_at) begin
          #1 rst_n = 1'b0;
          #1 check_outputs_zero("async_reset_outputs");
          exp_q.delete();
          model_reset();
          #1 rst_n = 1'b1;
          return;
        end
      end
    end
  endtask

  // Optional trailing partial frame (3 lines) to resynchronise, then n full frames.
  task automatic run_frames(input geo_t g, input int n, input bit partial);
    if (partial) drive_frame(g, g.v_tot - 3, -1, -1);
    for (int i = 0; i < n; i++) begin
      drive_frame(g, 0, -1, -1);
      check("timing_locked", timing_locked, m_locked);
      check("timing_err_count", err_seen, err_exp);
      if (i == 1)
        check("meas", {meas_h_total, meas_h_disp, meas_v_total, meas_v_disp},
              {11'(g.h_tot), 11'(g.h_act), 11'(g.v_tot), 11'(g.v_act)});
    end
  endtask

  initial begin
    int drop, sl, rst_at;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;

    // Standard stream: lock at the third vs edge, then whole locked frames.
    run_frames(g1, 4, 1);

    // One shortened active line: unlock with one error pulse, relock after two good frames.
    sl = $urandom_range(0, VD - 1);
    drive_frame(g1, 0, sl, -1);
    run_frames(g1, 3, 0);

    // Line sync stops while locked: watchdog drops lock once h_cnt saturates.
    drop = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      hs = 1'b1; vs = 1'b1; de = 1'b0;
      if (!timing_locked && drop < 0) drop = cyc;
    end
    model_watchdog();
    check("watchdog_drop_latency", drop - last_lead, 2050);
    check("watchdog_err_count", err_seen, err_exp);
    run_frames(g1, 3, 1);

    // Asynchronous reset in the middle of an active line, then relock from scratch.
    rst_at = (g1.v_sync + g1.v_bp + $urandom_range(0, VD - 1)) * g1.h_tot +
             $urandom_range(g1.h_sync + g1.h_bp, g1.h_sync + g1.h_bp + HD - 1);
    drive_frame(g1, 0, -1, rst_at);
    check("err_after_reset", err_seen, err_exp);
    run_frames(g1, 3, 1);

    // Foreign resolution: measured correctly, never locks, never writes.
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frames(g2, 3, 1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
